cu_hs: RTL
==========

# cu_hs

Multi-cycle CPU control unit that succeeds the single-cycle-memory CU. It decodes `ir`, evaluates the condition field against `status`, and sequences the register file, IR, MDR/MAR, ALU and memory strobes. Memory accesses use a request/acknowledge handshake with any number of wait states. It adds a HALT instruction, a vectored interrupt entry, and parametrised immediate masks.

## Interface
- `ALU_IMM_W`, 8: valid low bits of the IR operand for ALU-immediate ops; sets the `a_reg_mask`/`b_reg_mask` value.
- `MEM_IMM_W`, 16: valid low bits of the IR operand for LD/LDI/ST.
- `IRQ_VEC`, 32'h0000_0010: interrupt vector loaded into PC.
- `clk`  in  1  clock; all state changes happen on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  leaves STOP or HALT.
- `ir`  in  ir_t  current instruction register.
- `status`  in  status_t  ALU flags.
- `irq`  in  1  level interrupt request.
- `irq_en`  in  1  interrupt enable.
- `mem_ack`  in  1  memory completes the current access this cycle.
- `int_ack`  out  1  one-cycle pulse on interrupt entry.
- `halted`  out  1  high in STOP and HALT.
- `const_out`  out  32  constant bus, driven with `IRQ_VEC`.
- `oe_const`  out  1  drives `const_out` onto bus A.
- All remaining outputs keep the names, widths and meanings of the previous CU: `mem_rd`/`mem_wr`, the masks, the reg-file selects/counts/strobes, the IR, status, MDR, MAR and ALU controls.

## Operation
- States (`cu_state_e`): STOP, FETCH, ALU, LD, LDR, LDI, ST, STR, PUSH, POP, HALT, INT_PUSH, INT_JMP, NOP.
- Reset:
  - State goes to STOP.
  - Every output is 0, except `a_reg_mask` = `b_reg_mask` = 32'hffffffff and `halted` = 1.
- STOP / HALT:
  - Outputs idle.
  - `start` → FETCH.
- FETCH:
  - Drives `sel_b` = PC, `oe_b_reg_file` and `mem_rd` each cycle until `mem_ack`.
  - In the ack cycle only: `ld_ir`, `count_b` = 1, `post_count_b`.
  - FETCH always completes first; the interrupt check happens in the ack cycle.
- Exit from the FETCH ack cycle:
  - If `irq && irq_en` → INT_PUSH. The fetched IR is discarded: `ld_ir` is still strobed, but PC has already advanced and is restored by the handler's return path.
  - Else, if the condition fails → FETCH.
  - Else decode as the previous CU: 0x0? → ALU, LD, LDR, LDI, ST, STR, PUSH, POP, HALT, and anything else → NOP.
- ALU and LDI:
  - Single cycle, identical to the previous CU.
  - Masks are `(1<<ALU_IMM_W)-1` and `(1<<MEM_IMM_W)-1`.
- LD, LDR, ST, STR, POP:
  - Hold the address/data enables and `mem_rd`/`mem_wr` until `mem_ack`.
  - `ld_reg_file` and `post_count_b` are asserted only in the ack cycle.
- PUSH and INT_PUSH:
  - `pre_count_b` with `count_b` = -1 (8'hff), `sel_b` = SP, asserted only in the entry cycle.
  - `mem_wr` is held until ack.
  - INT_PUSH writes the PC (`sel_a` = PC).
- INT_JMP:
  - One cycle: `oe_const`, ALU PASSA, `oe_alu`, `ld_reg_file`, `sel_in` = PC, `int_ack` = 1.
  - Next state is FETCH.
- Every memory state returns to FETCH after its ack cycle, except INT_PUSH, which goes to INT_JMP.
- `start` is ignored outside STOP/HALT.
- `irq` is ignored outside the FETCH ack cycle.

## Timing
- The state register is clocked.
- Outputs are combinational in state, `ir` and `mem_ack` (Mealy on `mem_ack` only).
- Zero-wait memory: if `mem_ack` is high in the first cycle of a request, the access completes that cycle. Every memory state is then 1 cycle and FETCH is 1 cycle.
- N wait states add exactly N cycles. Strobes are held stable, and no count or load fires before the ack.
- Pre-count contract: the reg file commits the pre-count on the entry edge. Later cycles present the already-updated SP, so it is decremented exactly once.
- `mem_ack` outside a memory state is ignored.
- Asynchronous `rst` in any state, including mid-wait, forces STOP immediately. No further strobes are issued.
- Instruction latency with zero-wait memory:
  - Non-interrupted instruction: 2 cycles (fetch plus execute).
  - Interrupt entry: 3 cycles after the fetch ack.

## Structure
- `cpu_pkg` gains:
  - `cu_state_e`;
  - the `HALT` opcode;
  - `satisfies_condition()`, moved from the CU so other blocks can share it.
- Sub-module `mem_hs_seq`: a small helper that generates the entry-cycle pulse and ack-cycle pulse from (state-entered, `mem_ack`), used by all memory states.

## Test plan
- Reset mid-FETCH wait with `mem_ack` low → state STOP, `mem_rd` = 0, masks 32'hffffffff, `halted` = 1.
- Fetch then LDR r1←[r2] with `mem_ack` delayed 3 cycles → `mem_rd` high 4 cycles; `ld_reg_file` is a single pulse in the 4th cycle.
- PUSH r3 with 2 wait states → `pre_count_b` is 1 cycle only, `count_b` = 8'hff, `mem_wr` high 3 cycles.
- `irq` = 1, `irq_en` = 1 at a FETCH ack → INT_PUSH (`sel_a` = PC), then INT_JMP with `const_out` = 32'h10, `int_ack` one cycle, then FETCH.
- EQ-conditioned ADD with `status.zero` = 0 → returns to FETCH with no `ld_reg_file` or `ld_status`.
- HALT opcode → `halted` = 1 and no strobes for 10 cycles; `start` pulse → FETCH next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction/status layouts, opcodes, ALU ops, CU states and condition check.
package cpu_pkg;

  typedef struct packed {
    logic [3:0]  cond;
    logic [7:0]  opcode;
    logic [3:0]  ra;
    logic [15:0] operand;  // register ops use operand[3:0] as rb
  } ir_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } status_t;

  typedef enum logic [3:0] {
    CondAl, CondEq, CondNe, CondCs, CondCc, CondMi, CondPl, CondVs, CondVc, CondGe, CondLt
  } cond_e;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluShl, AluPassA, AluPassB
  } alu_op_e;

  typedef enum logic [3:0] {
    StStop, StFetch, StAlu, StLd, StLdr, StLdi, StSt, StStr, StPush, StPop, StHalt,
    StIntPush, StIntJmp, StNop
  } cu_state_e;

  // 0x0X is ALU: bit 3 selects the immediate form, bits 2:0 the ALU op.
  localparam logic [7:0] OpLd   = 8'h10;
  localparam logic [7:0] OpLdr  = 8'h11;
  localparam logic [7:0] OpLdi  = 8'h12;
  localparam logic [7:0] OpSt   = 8'h13;
  localparam logic [7:0] OpStr  = 8'h14;
  localparam logic [7:0] OpPush = 8'h15;
  localparam logic [7:0] OpPop  = 8'h16;
  localparam logic [7:0] OpHalt = 8'h17;

  localparam logic [3:0] RegSp = 4'd14;
  localparam logic [3:0] RegPc = 4'd15;

  function automatic logic satisfies_condition(input logic [3:0] cond, input status_t st);
    case (cond)
      CondAl:  return 1'b1;
      CondEq:  return st.zero;
      CondNe:  return !st.zero;
      CondCs:  return st.carry;
      CondCc:  return !st.carry;
      CondMi:  return st.negative;
      CondPl:  return !st.negative;
      CondVs:  return st.overflow;
      CondVc:  return !st.overflow;
      CondGe:  return st.negative == st.overflow;
      CondLt:  return st.negative != st.overflow;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_hs_seq.sv
// Memory handshake helper: first-cycle (entry) pulse and ack-cycle pulse of a memory state.
module mem_hs_seq (
  input  logic clk,
  input  logic rst,
  input  logic i_mem_state,
  input  logic i_mem_ack,
  output logic o_entry,
  output logic o_ack
);

  logic r_busy;

  // Set while a request is outstanding; cleared by the ack so the next state is a fresh entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= 1'b0;
    else     r_busy <= i_mem_state && !i_mem_ack;
  end

  assign o_entry = i_mem_state && !r_busy;
  assign o_ack   = i_mem_state && i_mem_ack;

endmodule

// File: rtl/cu_hs.sv
// Multi-cycle control unit with request/ack memory handshake, HALT and vectored interrupt entry.
module cu_hs
  import cpu_pkg::*;
#(
  parameter int unsigned ALU_IMM_W = 8,
  parameter int unsigned MEM_IMM_W = 16,
  parameter logic [31:0] IRQ_VEC   = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  ir_t         ir,
  input  status_t     status,
  input  logic        irq,
  input  logic        irq_en,
  input  logic        mem_ack,
  output cu_state_e   state,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] a_reg_mask,
  output logic [31:0] b_reg_mask,
  output logic [3:0]  sel_a,
  output logic [3:0]  sel_b,
  output logic [3:0]  sel_in,
  output logic        oe_a_reg_file,
  output logic        oe_b_reg_file,
  output logic        ld_reg_file,
  output logic [7:0]  count_b,
  output logic        pre_count_b,
  output logic        post_count_b,
  output logic        ld_ir,
  output logic        oe_ir_b,
  output logic        ld_status,
  output logic        oe_mdr,
  output alu_op_e     alu_op,
  output logic        oe_alu,
  output logic        int_ack,
  output logic        halted,
  output logic [31:0] const_out,
  output logic        oe_const
);

  localparam logic [31:0] AluMask = 32'((64'h1 << ALU_IMM_W) - 64'h1);
  localparam logic [31:0] MemMask = 32'((64'h1 << MEM_IMM_W) - 64'h1);

  cu_state_e r_state;
  logic      w_in_mem, w_entry, w_ack, w_unused;

  assign state    = r_state;
  assign w_in_mem = r_state inside {StFetch, StLd, StLdr, StSt, StStr, StPush, StPop, StIntPush};
  assign w_unused = ^ir.operand[15:4];

  mem_hs_seq u_mem_hs_seq (
    .clk         (clk),
    .rst         (rst),
    .i_mem_state (w_in_mem),
    .i_mem_ack   (mem_ack),
    .o_entry     (w_entry),
    .o_ack       (w_ack)
  );

  function automatic cu_state_e decode(input logic [7:0] op);
    if (op[7:4] == 4'h0) return StAlu;
    case (op)
      OpLd:    return StLd;
      OpLdr:   return StLdr;
      OpLdi:   return StLdi;
      OpSt:    return StSt;
      OpStr:   return StStr;
      OpPush:  return StPush;
      OpPop:   return StPop;
      OpHalt:  return StHalt;
      default: return StNop;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StStop;
    end else begin
      case (r_state)
        StStop, StHalt: if (start) r_state <= StFetch;
        StFetch: begin
          if (w_ack) begin
            if (irq && irq_en)                          r_state <= StIntPush;
            else if (!satisfies_condition(ir.cond, status)) r_state <= StFetch;
            else                                        r_state <= decode(ir.opcode);
          end
        end
        StLd, StLdr, StSt, StStr, StPush, StPop: if (w_ack) r_state <= StFetch;
        StIntPush: if (w_ack) r_state <= StIntJmp;
        default: r_state <= StFetch;  // ALU, LDI, NOP, INT_JMP
      endcase
    end
  end

  always_comb begin
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    a_reg_mask    = '1;
    b_reg_mask    = '1;
    sel_a         = '0;
    sel_b         = '0;
    sel_in        = '0;
    oe_a_reg_file = 1'b0;
    oe_b_reg_file = 1'b0;
    ld_reg_file   = 1'b0;
    count_b       = '0;
    pre_count_b   = 1'b0;
    post_count_b  = 1'b0;
    ld_ir         = 1'b0;
    oe_ir_b       = 1'b0;
    ld_status     = 1'b0;
    oe_mdr        = 1'b0;
    alu_op        = AluAdd;
    oe_alu        = 1'b0;
    int_ack       = 1'b0;
    halted        = 1'b0;
    const_out     = '0;
    oe_const      = 1'b0;
    unique case (r_state)
      StStop, StHalt: halted = 1'b1;
      StFetch: begin
        sel_b = RegPc; oe_b_reg_file = 1'b1; mem_rd = 1'b1;
        if (w_ack) begin
          ld_ir = 1'b1; count_b = 8'd1; post_count_b = 1'b1;
        end
      end
      StAlu: begin
        sel_a = ir.ra; oe_a_reg_file = 1'b1;
        alu_op = alu_op_e'(ir.opcode[2:0]);
        if (ir.opcode[3]) begin
          oe_ir_b = 1'b1; b_reg_mask = AluMask;
        end else begin
          sel_b = ir.operand[3:0]; oe_b_reg_file = 1'b1;
        end
        oe_alu = 1'b1; ld_reg_file = 1'b1; sel_in = ir.ra; ld_status = 1'b1;
      end
      StLd: begin
        oe_ir_b = 1'b1; b_reg_mask = MemMask; mem_rd = 1'b1; oe_mdr = 1'b1;
        sel_in = ir.ra; ld_reg_file = w_ack;
      end
      StLdr: begin
        sel_b = ir.operand[3:0]; oe_b_reg_file = 1'b1; mem_rd = 1'b1; oe_mdr = 1'b1;
        sel_in = ir.ra; ld_reg_file = w_ack;
      end
      StLdi: begin
        oe_ir_b = 1'b1; b_reg_mask = MemMask; alu_op = AluPassB; oe_alu = 1'b1;
        ld_reg_file = 1'b1; sel_in = ir.ra;
      end
      StSt: begin
        oe_ir_b = 1'b1; b_reg_mask = MemMask; sel_a = ir.ra; oe_a_reg_file = 1'b1;
        mem_wr = 1'b1;
      end
      StStr: begin
        sel_b = ir.operand[3:0]; oe_b_reg_file = 1'b1; sel_a = ir.ra; oe_a_reg_file = 1'b1;
        mem_wr = 1'b1;
      end
      StPush, StIntPush: begin
        // SP is decremented once on the entry edge; wait cycles see the updated SP.
        sel_b = RegSp; oe_b_reg_file = 1'b1;
        sel_a = (r_state == StIntPush) ? RegPc : ir.ra; oe_a_reg_file = 1'b1;
        mem_wr = 1'b1;
        if (w_entry) begin
          pre_count_b = 1'b1; count_b = 8'hff;
        end
      end
      StPop: begin
        sel_b = RegSp; oe_b_reg_file = 1'b1; mem_rd = 1'b1; oe_mdr = 1'b1; sel_in = ir.ra;
        if (w_ack) begin
          ld_reg_file = 1'b1; post_count_b = 1'b1; count_b = 8'd1;
        end
      end
      StIntJmp: begin
        oe_const = 1'b1; const_out = IRQ_VEC; alu_op = AluPassA; oe_alu = 1'b1;
        ld_reg_file = 1'b1; sel_in = RegPc; int_ack = 1'b1;
      end
      default: ;  // NOP
    endcase
  end

endmodule
